// File: rtl/debug_pd_counter_bank_if.sv
// Increment, byte-amount and CSR read-port signals between the debug PD stage, the counter bank and the CSR block.
interface debug_pd_counter_bank_if #(
    parameter int unsigned PACKET_SIZE_WIDTH = 12
);
    logic                         dbg2cif_e_debug_pd_field1_cnt_inc;
    logic                         dbg2cif_e_debug_pd_field2_cnt_inc;
    logic                         dbg2cif_e_debug_pd_capture_match_cnt_inc;
    logic                         dbg2cif_e_debug_pd_total_pd_cnt_inc;
    logic                         dbg2cif_e_debug_pd_field1_byte_cnt_inc;
    logic                         dbg2cif_e_debug_pd_field2_byte_cnt_inc;
    logic [PACKET_SIZE_WIDTH-1:0] dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount;
    logic                         cif2dbg_c_debug_pd_cnt_clear_all;
    logic                         cif2dbg_c_debug_pd_cnt_clr_on_rd;
    logic                         cif2dbg_e_debug_pd_cnt_rd_req;
    logic [2:0]                   cif2dbg_c_debug_pd_cnt_rd_sel;
    logic                         dbg2cif_e_debug_pd_cnt_rd_ack;
    logic [31:0]                  dbg2cif_c_debug_pd_cnt_rd_data;
    logic [5:0]                   dbg2cif_c_debug_pd_cnt_sat;

    modport master (
        output dbg2cif_e_debug_pd_field1_cnt_inc,
        output dbg2cif_e_debug_pd_field2_cnt_inc,
        output dbg2cif_e_debug_pd_capture_match_cnt_inc,
        output dbg2cif_e_debug_pd_total_pd_cnt_inc,
        output dbg2cif_e_debug_pd_field1_byte_cnt_inc,
        output dbg2cif_e_debug_pd_field2_byte_cnt_inc,
        output dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount,
        output cif2dbg_c_debug_pd_cnt_clear_all,
        output cif2dbg_c_debug_pd_cnt_clr_on_rd,
        output cif2dbg_e_debug_pd_cnt_rd_req,
        output cif2dbg_c_debug_pd_cnt_rd_sel,
        input  dbg2cif_e_debug_pd_cnt_rd_ack,
        input  dbg2cif_c_debug_pd_cnt_rd_data,
        input  dbg2cif_c_debug_pd_cnt_sat
    );

    modport slave (
        input  dbg2cif_e_debug_pd_field1_cnt_inc,
        input  dbg2cif_e_debug_pd_field2_cnt_inc,
        input  dbg2cif_e_debug_pd_capture_match_cnt_inc,
        input  dbg2cif_e_debug_pd_total_pd_cnt_inc,
        input  dbg2cif_e_debug_pd_field1_byte_cnt_inc,
        input  dbg2cif_e_debug_pd_field2_byte_cnt_inc,
        input  dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount,
        input  cif2dbg_c_debug_pd_cnt_clear_all,
        input  cif2dbg_c_debug_pd_cnt_clr_on_rd,
        input  cif2dbg_e_debug_pd_cnt_rd_req,
        input  cif2dbg_c_debug_pd_cnt_rd_sel,
        output dbg2cif_e_debug_pd_cnt_rd_ack,
        output dbg2cif_c_debug_pd_cnt_rd_data,
        output dbg2cif_c_debug_pd_cnt_sat
    );
endinterface

// File: rtl/debug_pd_counter_bank.sv
// Saturating debug PD statistics counters (4 event, 2 byte) with a 1-cycle CSR read port,
// clear-on-read, clear-all and lo/hi shadowing of the wide byte counters.
module debug_pd_counter_bank #(
    parameter int unsigned CNT_WIDTH         = 32,
    parameter int unsigned BYTE_CNT_WIDTH    = 48,
    parameter int unsigned PACKET_SIZE_WIDTH = 12
) (
    input logic                    clk,
    input logic                    rst,
    debug_pd_counter_bank_if.slave bus_if
);
    localparam int unsigned NUM_EVT  = 4;
    localparam int unsigned NUM_BYTE = 2;
    localparam int unsigned HI_WIDTH = BYTE_CNT_WIDTH - 32;
    localparam int unsigned SUM_WIDTH = BYTE_CNT_WIDTH + 1;

    logic [CNT_WIDTH-1:0]         evt_q    [NUM_EVT];
    logic [CNT_WIDTH-1:0]         evt_d    [NUM_EVT];
    logic [BYTE_CNT_WIDTH-1:0]    byte_q   [NUM_BYTE];
    logic [BYTE_CNT_WIDTH-1:0]    byte_d   [NUM_BYTE];
    logic [HI_WIDTH-1:0]          shadow_q [NUM_BYTE];
    logic [HI_WIDTH-1:0]          shadow_d [NUM_BYTE];
    logic [5:0]                   sat_q, sat_d;
    logic                         rd_ack_q, rd_ack_d;
    logic [31:0]                  rd_data_q, rd_data_d;

    logic [PACKET_SIZE_WIDTH-1:0] amount_c;
    logic [NUM_EVT-1:0]           evt_inc_c;
    logic [NUM_BYTE-1:0]          byte_inc_c;
    logic [5:0]                   clr_c;
    logic [SUM_WIDTH-1:0]         sum_c    [NUM_BYTE];
    logic [31:0]                  rd_mux_c;

    assign amount_c   = bus_if.dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount;
    assign evt_inc_c  = {bus_if.dbg2cif_e_debug_pd_total_pd_cnt_inc,
                         bus_if.dbg2cif_e_debug_pd_capture_match_cnt_inc,
                         bus_if.dbg2cif_e_debug_pd_field2_cnt_inc,
                         bus_if.dbg2cif_e_debug_pd_field1_cnt_inc};
    assign byte_inc_c = {bus_if.dbg2cif_e_debug_pd_field2_byte_cnt_inc,
                         bus_if.dbg2cif_e_debug_pd_field1_byte_cnt_inc};

    // Clear-on-read targets, indexed like the sat vector (hi-word selects never clear)
    always_comb begin
        clr_c = '0;
        if (bus_if.cif2dbg_e_debug_pd_cnt_rd_req && bus_if.cif2dbg_c_debug_pd_cnt_clr_on_rd) begin
            case (bus_if.cif2dbg_c_debug_pd_cnt_rd_sel)
                3'd0:    clr_c[0] = 1'b1;
                3'd1:    clr_c[1] = 1'b1;
                3'd2:    clr_c[2] = 1'b1;
                3'd3:    clr_c[3] = 1'b1;
                3'd4:    clr_c[4] = 1'b1;
                3'd6:    clr_c[5] = 1'b1;
                default: clr_c    = '0;
            endcase
        end
    end

    // Read mux over pre-edge values
    always_comb begin
        case (bus_if.cif2dbg_c_debug_pd_cnt_rd_sel)
            3'd0: rd_mux_c = 32'(evt_q[0]);
            3'd1: rd_mux_c = 32'(evt_q[1]);
            3'd2: rd_mux_c = 32'(evt_q[2]);
            3'd3: rd_mux_c = 32'(evt_q[3]);
            3'd4: rd_mux_c = byte_q[0][31:0];
            3'd5: rd_mux_c = 32'(shadow_q[0]);
            3'd6: rd_mux_c = byte_q[1][31:0];
            3'd7: rd_mux_c = 32'(shadow_q[1]);
        endcase
    end

    always_comb begin
        sat_d     = sat_q;
        rd_ack_d  = bus_if.cif2dbg_e_debug_pd_cnt_rd_req;
        rd_data_d = bus_if.cif2dbg_e_debug_pd_cnt_rd_req ? rd_mux_c : rd_data_q;

        for (int i = 0; i < NUM_EVT; i++) begin
            evt_d[i] = evt_q[i];
            if (clr_c[i]) begin
                evt_d[i] = CNT_WIDTH'(evt_inc_c[i]);
                sat_d[i] = 1'b0;
            end else if (evt_inc_c[i]) begin
                if (evt_q[i] == '1) begin
                    sat_d[i] = 1'b1;
                end else begin
                    evt_d[i] = evt_q[i] + CNT_WIDTH'(1);
                end
            end
        end

        for (int j = 0; j < NUM_BYTE; j++) begin
            sum_c[j]    = {1'b0, byte_q[j]} + SUM_WIDTH'(amount_c);
            byte_d[j]   = byte_q[j];
            shadow_d[j] = shadow_q[j];
            if (clr_c[4+j]) begin
                byte_d[j]  = byte_inc_c[j] ? BYTE_CNT_WIDTH'(amount_c) : '0;
                sat_d[4+j] = 1'b0;
            end else if (byte_inc_c[j]) begin
                if (sum_c[j][BYTE_CNT_WIDTH]) begin
                    byte_d[j]  = '1;
                    sat_d[4+j] = 1'b1;
                end else begin
                    byte_d[j] = sum_c[j][BYTE_CNT_WIDTH-1:0];
                end
            end
        end

        // Lo-word read freezes the matching hi word for a later atomic hi read
        if (bus_if.cif2dbg_e_debug_pd_cnt_rd_req) begin
            if (bus_if.cif2dbg_c_debug_pd_cnt_rd_sel == 3'd4) shadow_d[0] = byte_q[0][BYTE_CNT_WIDTH-1:32];
            if (bus_if.cif2dbg_c_debug_pd_cnt_rd_sel == 3'd6) shadow_d[1] = byte_q[1][BYTE_CNT_WIDTH-1:32];
        end

        if (bus_if.cif2dbg_c_debug_pd_cnt_clear_all) begin
            for (int i = 0; i < NUM_EVT; i++) evt_d[i] = '0;
            for (int j = 0; j < NUM_BYTE; j++) begin
                byte_d[j]   = '0;
                shadow_d[j] = '0;
            end
            sat_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_EVT; i++) evt_q[i] <= '0;
            for (int j = 0; j < NUM_BYTE; j++) begin
                byte_q[j]   <= '0;
                shadow_q[j] <= '0;
            end
            sat_q     <= '0;
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            for (int i = 0; i < NUM_EVT; i++) evt_q[i] <= evt_d[i];
            for (int j = 0; j < NUM_BYTE; j++) begin
                byte_q[j]   <= byte_d[j];
                shadow_q[j] <= shadow_d[j];
            end
            sat_q     <= sat_d;
            rd_ack_q  <= rd_ack_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus_if.dbg2cif_e_debug_pd_cnt_rd_ack  = rd_ack_q;
    assign bus_if.dbg2cif_c_debug_pd_cnt_rd_data = rd_data_q;
    assign bus_if.dbg2cif_c_debug_pd_cnt_sat     = sat_q;
endmodule

// File: tb/tb_debug_pd_counter_bank.sv
// Directed bench for debug_pd_counter_bank: 4-bit event counters, 48-bit byte counters, 32-bit amounts.
module tb_debug_pd_counter_bank;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BYTE_W = 48;
    localparam int unsigned PKT_W  = 32;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    debug_pd_counter_bank_if #(.PACKET_SIZE_WIDTH(PKT_W)) bus_if ();

    debug_pd_counter_bank #(
        .CNT_WIDTH        (CNT_W),
        .BYTE_CNT_WIDTH   (BYTE_W),
        .PACKET_SIZE_WIDTH(PKT_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_if(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic all_incs(input logic v);
        bus_if.dbg2cif_e_debug_pd_field1_cnt_inc        = v;
        bus_if.dbg2cif_e_debug_pd_field2_cnt_inc        = v;
        bus_if.dbg2cif_e_debug_pd_capture_match_cnt_inc = v;
        bus_if.dbg2cif_e_debug_pd_total_pd_cnt_inc      = v;
        bus_if.dbg2cif_e_debug_pd_field1_byte_cnt_inc   = v;
        bus_if.dbg2cif_e_debug_pd_field2_byte_cnt_inc   = v;
    endtask

    // One read strobe; rd_req stays high so consecutive calls are back-to-back
    task automatic rd(input logic [2:0] sel, input logic [31:0] exp, input string tag);
        bus_if.cif2dbg_e_debug_pd_cnt_rd_req = 1'b1;
        bus_if.cif2dbg_c_debug_pd_cnt_rd_sel = sel;
        step();
        chk({tag, "_ack"}, 32'(bus_if.dbg2cif_e_debug_pd_cnt_rd_ack), 32'd1);
        chk({tag, "_data"}, bus_if.dbg2cif_c_debug_pd_cnt_rd_data, exp);
    endtask

    task automatic idle();
        bus_if.cif2dbg_e_debug_pd_cnt_rd_req = 1'b0;
        all_incs(1'b0);
        step();
        chk("idle_ack", 32'(bus_if.dbg2cif_e_debug_pd_cnt_rd_ack), 32'd0);
    endtask

    task automatic field1_incs(input int n);
        bus_if.dbg2cif_e_debug_pd_field1_cnt_inc = 1'b1;
        repeat (n) step();
        bus_if.dbg2cif_e_debug_pd_field1_cnt_inc = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        all_incs(1'b0);
        bus_if.dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount = '0;
        bus_if.cif2dbg_c_debug_pd_cnt_clear_all = 1'b0;
        bus_if.cif2dbg_c_debug_pd_cnt_clr_on_rd = 1'b0;
        bus_if.cif2dbg_e_debug_pd_cnt_rd_req    = 1'b0;
        bus_if.cif2dbg_c_debug_pd_cnt_rd_sel    = 3'd0;
        step();
        step();
        chk("rst_ack", 32'(bus_if.dbg2cif_e_debug_pd_cnt_rd_ack), 32'd0);
        chk("rst_data", bus_if.dbg2cif_c_debug_pd_cnt_rd_data, 32'd0);
        chk("rst_sat", 32'(bus_if.dbg2cif_c_debug_pd_cnt_sat), 32'd0);
        rst = 1'b0;
        step();

        // Five total-PD increments, single read with ack and data hold
        bus_if.dbg2cif_e_debug_pd_total_pd_cnt_inc = 1'b1;
        repeat (5) step();
        bus_if.dbg2cif_e_debug_pd_total_pd_cnt_inc = 1'b0;
        rd(3'd3, 32'd5, "total5");
        chk("total5_sat", 32'(bus_if.dbg2cif_c_debug_pd_cnt_sat), 32'd0);
        idle();
        chk("hold_data", bus_if.dbg2cif_c_debug_pd_cnt_rd_data, 32'd5);

        // Event saturation at 4 bits, then clear-on-read drops counter and sat
        field1_incs(17);
        rd(3'd0, 32'd15, "f1_sat");
        chk("f1_sat_flag", 32'(bus_if.dbg2cif_c_debug_pd_cnt_sat), 32'h01);
        idle();
        bus_if.cif2dbg_c_debug_pd_cnt_clr_on_rd = 1'b1;
        rd(3'd0, 32'd15, "f1_cor");
        chk("f1_cor_sat", 32'(bus_if.dbg2cif_c_debug_pd_cnt_sat), 32'd0);
        rd(3'd0, 32'd0, "f1_after_cor");
        idle();
        bus_if.cif2dbg_c_debug_pd_cnt_clr_on_rd = 1'b0;

        // Byte counters: lo read freezes hi word into shadow
        bus_if.dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount = 32'hFFFF_FFF0;
        bus_if.dbg2cif_e_debug_pd_field1_byte_cnt_inc = 1'b1;
        bus_if.dbg2cif_e_debug_pd_field2_byte_cnt_inc = 1'b1;
        step();
        all_incs(1'b0);
        rd(3'd7, 32'd0, "f2B_hi_pre");
        rd(3'd4, 32'hFFFF_FFF0, "f1B_lo");
        rd(3'd5, 32'd0, "f1B_hi");
        idle();
        bus_if.dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount = 32'h20;
        bus_if.dbg2cif_e_debug_pd_field1_byte_cnt_inc = 1'b1;
        step();
        all_incs(1'b0);
        rd(3'd5, 32'd0, "f1B_hi_shadow");
        rd(3'd4, 32'h10, "f1B_lo2");
        rd(3'd5, 32'd1, "f1B_hi2");
        rd(3'd6, 32'hFFFF_FFF0, "f2B_lo");
        rd(3'd7, 32'd0, "f2B_hi");
        chk("bytes_sat", 32'(bus_if.dbg2cif_c_debug_pd_cnt_sat), 32'd0);
        idle();

        // Clear-on-read with same-cycle increment keeps the increment
        bus_if.dbg2cif_e_debug_pd_field2_cnt_inc = 1'b1;
        repeat (7) step();
        bus_if.cif2dbg_c_debug_pd_cnt_clr_on_rd = 1'b1;
        rd(3'd1, 32'd7, "f2_race");
        bus_if.dbg2cif_e_debug_pd_field2_cnt_inc = 1'b0;
        rd(3'd1, 32'd1, "f2_after_race");
        idle();
        bus_if.cif2dbg_c_debug_pd_cnt_clr_on_rd = 1'b0;

        // clear_all with all increments and a read in the same cycle
        bus_if.dbg2cif_e_debug_pd_capture_match_cnt_inc = 1'b1;
        repeat (3) step();
        bus_if.dbg2cif_e_debug_pd_capture_match_cnt_inc = 1'b0;
        field1_incs(16);
        chk("pre_clr_sat", 32'(bus_if.dbg2cif_c_debug_pd_cnt_sat), 32'h01);
        all_incs(1'b1);
        bus_if.dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount = 32'd5;
        bus_if.cif2dbg_c_debug_pd_cnt_clear_all = 1'b1;
        rd(3'd2, 32'd3, "clr_all_rd");
        chk("clr_all_sat", 32'(bus_if.dbg2cif_c_debug_pd_cnt_sat), 32'd0);
        all_incs(1'b0);
        bus_if.cif2dbg_c_debug_pd_cnt_clear_all = 1'b0;
        for (int s = 0; s < 8; s++) rd(3'(s), 32'd0, $sformatf("clr_all_sel%0d", s));
        idle();

        // Reset with a read strobe in the same cycle: read dropped, outputs cleared
        field1_incs(17);
        bus_if.dbg2cif_e_debug_pd_total_pd_cnt_inc = 1'b1;
        repeat (2) step();
        bus_if.dbg2cif_e_debug_pd_total_pd_cnt_inc = 1'b0;
        rd(3'd3, 32'd2, "pre_rst_rd");
        chk("pre_rst_sat", 32'(bus_if.dbg2cif_c_debug_pd_cnt_sat), 32'h01);
        rst = 1'b1;
        step();
        chk("rst_rd_ack", 32'(bus_if.dbg2cif_e_debug_pd_cnt_rd_ack), 32'd0);
        chk("rst_rd_data", bus_if.dbg2cif_c_debug_pd_cnt_rd_data, 32'd0);
        chk("rst_rd_sat", 32'(bus_if.dbg2cif_c_debug_pd_cnt_sat), 32'd0);
        rst = 1'b0;
        bus_if.cif2dbg_e_debug_pd_cnt_rd_req = 1'b0;
        step();
        rd(3'd3, 32'd0, "post_rst_total");
        rd(3'd0, 32'd0, "post_rst_f1");
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
